correlator_multi: RTL
=====================

CORRELATOR_MULTI -- requirements
Module: correlator_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels, legal range 2..8.
REQ-002 SHALL have parameter MAX_WINDOW_LENGTH_EXP, default 16, log2 of the maximum window length in samples, legal range 8..16; TIME_W equals this value.
REQ-003 SHALL have parameter MAX_SAMPLE_PERIOD_EXP, default 15, log2 of the maximum sample period in cycles.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_cg, input, 1 bit: clock-gate enable; when low, no state updates.
REQ-007 SHALL have port i_windowLengthExp, input, clog2(MAX_WINDOW_LENGTH_EXP+1) bits: window length is 2^value samples.
REQ-008 SHALL have port i_samplePeriodExp, input, clog2(MAX_SAMPLE_PERIOD_EXP+1) bits: sample period is 2^value cycles.
REQ-009 SHALL have port i_refSel, input, clog2(N_CH) bits: reference channel index.
REQ-010 SHALL have port i_cfgWr, input, 1 bit: configuration-change pulse.
REQ-011 SHALL have port i_x, input, N_CH bits: binary channel inputs.
REQ-012 SHALL have port o_data, output, 8 bits: packet byte.
REQ-013 SHALL have port o_valid, output, 1 bit: o_data valid.
REQ-014 SHALL have port i_ready, input, 1 bit: consumer accepts o_data.
REQ-015 SHALL have port o_busy, output, 1 bit: packet transmission in progress (equals o_valid).

Function
REQ-016 SHALL assert a sample strobe when the period counter equals 2^i_samplePeriodExp-1, then clear the counter; value 0 gives a strobe every enabled cycle.
REQ-017 SHALL register i_x on each strobe; all counting uses the registered sample of the previous strobe.
REQ-018 SHALL, on each strobe, increment count[c] when sample[c]=1, and isect[c] when sample[c] AND sample[i_refSel] are both 1, for every c.
REQ-019 SHALL saturate every counter at all-ones (TIME_W bits) and never wrap.
REQ-020 SHALL end a window on the strobe where the low i_windowLengthExp bits of the sample index t are all ones (every strobe when i_windowLengthExp=0); that strobe's sample is included.
REQ-021 SHALL, at window end, snapshot all counters, zero them and t in the same cycle, and increment 8-bit winNum (wraps 255->0) regardless of transmitter state.
REQ-022 SHALL report each counter as byte = bits [TIME_W-1 -: 8] of (value << (MAX_WINDOW_LENGTH_EXP - i_windowLengthExp)), with saturation to 8'hFF when shifted-out bits are nonzero.
REQ-023 SHALL emit a packet of 2+2*N_CH bytes: winNum, status {drop, 4'b0, refSel zero-extended to 3 bits}, then count[0], isect[0], ..., count[N_CH-1], isect[N_CH-1].
REQ-024 SHALL transmit through FSM states IDLE -> SEND (byte index 0..2+2*N_CH-1) -> IDLE; IDLE->SEND on the cycle after window end.
REQ-025 SHALL hold o_data stable while o_valid=1 and i_ready=0; the byte index advances only on o_valid && i_ready; the last byte accepted returns to IDLE.
REQ-026 SHALL, when a window ends while in SEND, discard that snapshot, keep the current packet unchanged, and set sticky flag drop.
REQ-027 SHALL place drop in the next transmitted status byte and clear it when that packet starts; a drop occurring in the same cycle as a packet start sets drop again.
REQ-028 SHALL, on i_cfgWr, zero the period counter, t and all counters without emitting a packet; an in-flight packet completes unaffected.
REQ-029 SHALL give i_cfgWr priority over a coincident window end (no snapshot taken).

Reset
REQ-030 SHALL, while i_rst_n=0, asynchronously force IDLE, o_valid=0, o_busy=0, o_data=8'h00, winNum=0, drop=0, and zero all counters, t and the period counter.
REQ-031 SHALL leave the first strobe after reset release to occur 2^i_samplePeriodExp enabled cycles after release.

Verification
REQ-032 N_CH=4, period exp 0, window exp 8, i_x=4'b0011, refSel=0, i_ready=1 -> packet {0, 8'h00, FF,FF, FF,FF, 00,00, 00,00} after the first window (first window includes the reset-value sample, so counts are 255 -> 8'hFF after shift).
REQ-033 Window exp 0, period exp 0, i_ready=0 for 40 cycles -> first packet held stable, later windows set drop; after release, the next packet has status bit7=1 and a winNum gap.
REQ-034 Window exp 16, i_x all ones for 2^16 strobes -> counters saturate, bytes 8'hFF, no wrap to 0.
REQ-035 i_cfgWr mid-window with coincident window-end strobe -> no packet, counters zero, winNum unchanged.
REQ-036 i_rst_n asserted mid-packet with i_ready toggling -> o_valid drops immediately; after release, winNum restarts at 0.

Source files
------------

// File: rtl/correlator_multi.sv
// -----------------------------------------------------------------------------
// correlator_multi
//
// Multi-channel binary correlator. On every sample strobe it counts, for each
// channel c, how often the previously registered sample was 1 (count[c]) and
// how often it was 1 together with the reference channel (isect[c]). At the
// end of each window the counters are scaled to bytes and sent out as a packet
// over a valid/ready byte stream:
//   winNum, status {drop, 4'b0, refSel}, count[0], isect[0], ... , isect[N-1]
//
// Ports
//   i_clk              single clock
//   i_rst_n            asynchronous active-low reset
//   i_cg               clock-gate enable; all state holds while low
//   i_windowLengthExp  window length = 2^value samples
//   i_samplePeriodExp  sample period = 2^value enabled cycles
//   i_refSel           reference channel index
//   i_cfgWr            configuration-change pulse; restarts the current window
//   i_x                binary channel inputs
//   o_data             packet byte
//   o_valid            o_data valid
//   i_ready            consumer accepts o_data
//   o_busy             packet transmission in progress (same as o_valid)
// -----------------------------------------------------------------------------
module correlator_multi #(
    parameter int N_CH                  = 4,
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_cg,
    input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] i_windowLengthExp,
    input  logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] i_samplePeriodExp,
    input  logic [$clog2(N_CH)-1:0]                    i_refSel,
    input  logic                                       i_cfgWr,
    input  logic [N_CH-1:0]                            i_x,
    output logic [7:0]                                 o_data,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic                                       o_busy
);

    localparam int TIME_W = MAX_WINDOW_LENGTH_EXP;
    localparam int WL_W   = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam int PC_W   = (MAX_SAMPLE_PERIOD_EXP < 1) ? 1 : MAX_SAMPLE_PERIOD_EXP;
    localparam int NB     = 2 + 2 * N_CH;
    localparam int IDX_W  = $clog2(NB);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
        return (&v) ? v : v + TIME_W'(1);
    endfunction

    // Scale a window count to the full TIME_W range and keep the top byte.
    // Any bit shifted past the top means the count overflowed the byte scale.
    function automatic logic [7:0] rep_byte(input logic [TIME_W-1:0] v,
                                            input logic [WL_W-1:0]   wexp);
        logic [2*TIME_W-1:0] shifted;
        logic [WL_W-1:0]     sh;
        sh      = (wexp >= WL_W'(TIME_W)) ? '0 : WL_W'(TIME_W) - wexp;
        shifted = {{TIME_W{1'b0}}, v} << sh;
        if (|shifted[2*TIME_W-1:TIME_W]) begin
            return 8'hFF;
        end
        return shifted[TIME_W-1 -: 8];
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic [PC_W-1:0]     pcnt_q, pcnt_d;
    logic [TIME_W-1:0]   t_q, t_d;
    logic [N_CH-1:0]     sample_q, sample_d;
    logic [7:0]          winnum_q, winnum_d;
    logic                drop_q, drop_d;
    logic [TIME_W-1:0]   cnt_q [N_CH];
    logic [TIME_W-1:0]   cnt_d [N_CH];
    logic [TIME_W-1:0]   isc_q [N_CH];
    logic [TIME_W-1:0]   isc_d [N_CH];
    logic [7:0]          pkt_q [NB];
    logic [7:0]          pkt_d [NB];

    logic [TIME_W-1:0]   inc_cnt [N_CH];
    logic [TIME_W-1:0]   inc_isc [N_CH];
    logic [PC_W:0]       period_last;
    logic [TIME_W:0]     win_mask;
    logic                strobe;
    logic                win_end;
    logic                ref_bit;
    logic [2:0]          ref3;
    logic                pkt_start;
    logic                pkt_drop;

    assign period_last = ((PC_W+1)'(1) << i_samplePeriodExp) - (PC_W+1)'(1);
    assign strobe      = ({1'b0, pcnt_q} == period_last);
    // Window ends when the low windowLengthExp bits of t are all ones.
    assign win_mask    = ((TIME_W+1)'(1) << i_windowLengthExp) - (TIME_W+1)'(1);
    assign win_end     = strobe &&
                         ((t_q & win_mask[TIME_W-1:0]) == win_mask[TIME_W-1:0]);
    assign ref_bit     = sample_q[i_refSel];
    assign ref3        = 3'(i_refSel);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pcnt_d    = pcnt_q;
        t_d       = t_q;
        sample_d  = sample_q;
        winnum_d  = winnum_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        isc_d     = isc_q;
        pkt_d     = pkt_q;
        pkt_start = 1'b0;
        pkt_drop  = 1'b0;

        // Counting always uses the sample registered on the previous strobe.
        for (int c = 0; c < N_CH; c++) begin
            inc_cnt[c] = sample_q[c] ? sat_inc(cnt_q[c]) : cnt_q[c];
            inc_isc[c] = (sample_q[c] && ref_bit) ? sat_inc(isc_q[c]) : isc_q[c];
        end

        // Transmitter: advance only on a completed handshake.
        if (state_q == ST_SEND && valid_q && i_ready) begin
            if (idx_q == IDX_W'(NB - 1)) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
                data_d = pkt_q[idx_q + IDX_W'(1)];
            end
        end

        if (strobe) begin
            sample_d = i_x;
        end
        pcnt_d = strobe ? '0 : pcnt_q + PC_W'(1);

        // A config write restarts the window and beats a coincident window end.
        if (i_cfgWr) begin
            pcnt_d = '0;
            t_d    = '0;
            cnt_d  = '{default: '0};
            isc_d  = '{default: '0};
        end else if (strobe) begin
            if (win_end) begin
                t_d      = '0;
                winnum_d = winnum_q + 8'd1;
                cnt_d    = '{default: '0};
                isc_d    = '{default: '0};
                if (state_q == ST_SEND) begin
                    // Transmitter busy: this window's result is lost.
                    pkt_drop = 1'b1;
                end else begin
                    pkt_start = 1'b1;
                    pkt_d[0]  = winnum_q;
                    pkt_d[1]  = {drop_q, 4'b0000, ref3};
                    for (int c = 0; c < N_CH; c++) begin
                        pkt_d[2+2*c] = rep_byte(inc_cnt[c], i_windowLengthExp);
                        pkt_d[3+2*c] = rep_byte(inc_isc[c], i_windowLengthExp);
                    end
                    state_d = ST_SEND;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = winnum_q;
                end
            end else begin
                t_d   = t_q + TIME_W'(1);
                cnt_d = inc_cnt;
                isc_d = inc_isc;
            end
        end

        // Starting a packet reports and clears drop; a new drop re-arms it.
        if (pkt_start) begin
            drop_d = 1'b0;
        end
        if (pkt_drop) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            pcnt_q   <= '0;
            t_q      <= '0;
            sample_q <= '0;
            winnum_q <= 8'h00;
            drop_q   <= 1'b0;
            cnt_q    <= '{default: '0};
            isc_q    <= '{default: '0};
            pkt_q    <= '{default: '0};
        end else if (i_cg) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            pcnt_q   <= pcnt_d;
            t_q      <= t_d;
            sample_q <= sample_d;
            winnum_q <= winnum_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            isc_q    <= isc_d;
            pkt_q    <= pkt_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = valid_q;

endmodule
